// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave register bank: parametrised width/depth, byte strobes, AW/W in any order,
// SLVERR on out-of-range words, alternating read/write grant under contention.
module axi4_lite_regfile_slave #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDRESS-1:0]      S_AWADDR,
  input  logic                    S_AWVALID,
  output logic                    S_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
  input  logic                    S_WVALID,
  output logic                    S_WREADY,
  output logic [1:0]              S_BRESP,
  output logic                    S_BVALID,
  input  logic                    S_BREADY,
  input  logic [ADDRESS-1:0]      S_ARADDR,
  input  logic                    S_ARVALID,
  output logic                    S_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_RDATA,
  output logic [1:0]              S_RRESP,
  output logic                    S_RVALID,
  input  logic                    S_RREADY
);
  localparam int SW    = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(SW);
  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDRESS-1:0] NREGS_A = ADDRESS'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_ACCEPT, WR_RESP, RD_RESP} state_t;
  typedef struct packed {
    logic [ADDRESS-1:0]    addr;
    logic [DATA_WIDTH-1:0] data;
    logic [SW-1:0]         strb;
  } wr_req_t;

  state_t                state;
  wr_req_t               held_q, wr_eff;
  logic                  aw_held, w_held, last_wr;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  wr_req, rd_req, grant_wr, grant_rd;
  logic                  aw_hs, w_hs, ar_hs, do_wr, wr_ok, rd_ok;
  logic [ADDRESS-1:0]    wr_word, rd_word;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [SW-1:0]         lane_we;
  logic [SW-1:0][7:0]    rd_lane;

  // Contention alternates: last_wr=0 (reset) means the write side wins next.
  always_comb begin
    wr_req   = S_AWVALID | S_WVALID;
    rd_req   = S_ARVALID;
    grant_wr = wr_req & (~rd_req | ~last_wr);
    grant_rd = rd_req & ~grant_wr;
    ar_hs    = (state == IDLE) & grant_rd;
    aw_hs    = (state == WR_ACCEPT) & ~aw_held & S_AWVALID;
    w_hs     = (state == WR_ACCEPT) & ~w_held & S_WVALID;
    do_wr    = (state == WR_ACCEPT) & (aw_held | aw_hs) & (w_held | w_hs);
  end

  // The write commits on the edge the second half arrives, so merge held and live payloads.
  always_comb begin
    wr_eff.addr = aw_held ? held_q.addr : S_AWADDR;
    wr_eff.data = w_held  ? held_q.data : S_WDATA;
    wr_eff.strb = w_held  ? held_q.strb : S_WSTRB;
  end

  assign wr_word = wr_eff.addr >> OFS;
  assign rd_word = S_ARADDR >> OFS;
  assign wr_ok   = wr_word < NREGS_A;
  assign rd_ok   = rd_word < NREGS_A;
  assign wr_idx  = wr_word[IDX_W-1:0];
  assign rd_idx  = rd_word[IDX_W-1:0];

  genvar b;
  generate
    for (b = 0; b < SW; b++) begin : g_lane
      logic [NUM_REGS-1:0][7:0] mem;
      assign lane_we[b] = do_wr & wr_ok & wr_eff.strb[b];
      assign rd_lane[b] = mem[rd_idx];
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN)        mem         <= '0;
        else if (lane_we[b]) mem[wr_idx] <= wr_eff.data[8*b +: 8];
      end
    end
  endgenerate

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= IDLE;
      held_q   <= '0;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      last_wr  <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_wr) begin
            state   <= WR_ACCEPT;
            last_wr <= 1'b1;
          end else if (grant_rd) begin
            state    <= RD_RESP;
            last_wr  <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= rd_ok ? DATA_WIDTH'(rd_lane) : '0;
            rresp_q  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        WR_ACCEPT: begin
          if (do_wr) begin
            state    <= WR_RESP;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (aw_hs) begin
              aw_held     <= 1'b1;
              held_q.addr <= S_AWADDR;
            end
            if (w_hs) begin
              w_held      <= 1'b1;
              held_q.data <= S_WDATA;
              held_q.strb <= S_WSTRB;
            end
          end
        end
        WR_RESP: begin
          if (S_BREADY) begin
            state    <= IDLE;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
          end
        end
        RD_RESP: begin
          if (S_RREADY) begin
            state    <= IDLE;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign S_AWREADY = (state == WR_ACCEPT) & ~aw_held;
  assign S_WREADY  = (state == WR_ACCEPT) & ~w_held;
  assign S_ARREADY = ar_hs;
  assign S_BVALID  = bvalid_q;
  assign S_BRESP   = bresp_q;
  assign S_RVALID  = rvalid_q;
  assign S_RRESP   = rresp_q;
  assign S_RDATA   = rdata_q;
endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Self-checking bench: randomized AXI4-Lite traffic against an array model of the register bank.
module tb_axi4_lite_regfile_slave;
  localparam int AW = 32, DW = 32, NR = 32;

  logic          ACLK = 1'b0, ARESETN = 1'b0;
  logic [AW-1:0] S_AWADDR, S_ARADDR;
  logic          S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_BVALID, S_BREADY;
  logic          S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
  logic [DW-1:0] S_WDATA, S_RDATA;
  logic [3:0]    S_WSTRB;
  logic [1:0]    S_BRESP, S_RRESP;

  int checks = 0, errors = 0;
  logic [DW-1:0] model [NR];

  axi4_lite_regfile_slave #(.ADDRESS(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #600000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic bit in_range(input logic [AW-1:0] a);
    return (a / 4) < NR;
  endfunction

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s);
    if (in_range(a))
      for (int i = 0; i < 4; i++)
        if (s[i]) model[a/4][8*i +: 8] = d[8*i +: 8];
  endtask

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return in_range(a) ? model[a/4] : '0;
  endfunction

  task automatic idle_inputs();
    S_AWADDR = '0; S_AWVALID = 0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = 0;
    S_BREADY = 0; S_ARADDR = '0; S_ARVALID = 0; S_RREADY = 0;
  endtask

  task automatic apply_reset();
    ARESETN = 0;
    idle_inputs();
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1;
    for (int i = 0; i < NR; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_hold,
                          output logic [1:0] resp, output bit ok, output bit early_b, output bit unstable);
    bit aw_done = 0, w_done = 0;
    int cyc = 0;
    ok = 1; early_b = 0; unstable = 0; resp = 2'bxx;
    S_AWADDR = a; S_WDATA = d; S_WSTRB = s; S_BREADY = 0;
    while (!(aw_done && w_done)) begin
      if (cyc > 100) begin ok = 0; break; end
      S_AWVALID = !aw_done && cyc >= aw_dly;
      S_WVALID  = !w_done && cyc >= w_dly;
      @(negedge ACLK);
      if (S_BVALID) early_b = 1;
      if (S_AWVALID && S_AWREADY) aw_done = 1;
      if (S_WVALID && S_WREADY) w_done = 1;
      @(posedge ACLK); #1;
      cyc++;
    end
    S_AWVALID = 0; S_WVALID = 0;
    if (!ok) return;
    cyc = 0;
    do begin
      @(negedge ACLK);
      if (++cyc > 50) begin ok = 0; return; end
    end while (!S_BVALID);
    resp = S_BRESP;
    for (int i = 0; i < b_hold; i++) begin
      @(negedge ACLK);
      if (!S_BVALID || S_BRESP !== resp) unstable = 1;
    end
    S_BREADY = 1;
    @(posedge ACLK); #1;
    S_BREADY = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int r_hold,
                         output logic [DW-1:0] d, output logic [1:0] resp, output int lat,
                         output bit ok, output bit unstable);
    int cyc = 0;
    ok = 1; unstable = 0; lat = 0; d = 'x; resp = 2'bxx;
    S_ARADDR = a; S_ARVALID = 1; S_RREADY = 0;
    forever begin
      @(negedge ACLK);
      if (S_ARREADY) break;
      if (++cyc > 50) begin ok = 0; S_ARVALID = 0; return; end
    end
    @(posedge ACLK); #1;
    S_ARVALID = 0;
    do begin
      @(negedge ACLK);
      if (++lat > 50) begin ok = 0; return; end
    end while (!S_RVALID);
    d = S_RDATA; resp = S_RRESP;
    for (int i = 0; i < r_hold; i++) begin
      @(negedge ACLK);
      if (!S_RVALID || S_RDATA !== d || S_RRESP !== resp) unstable = 1;
    end
    S_RREADY = 1;
    @(posedge ACLK); #1;
    S_RREADY = 0;
  endtask

  task automatic test_reset();
    ARESETN = 0;
    idle_inputs();
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID});
    end
    checks++;
    if ({S_RDATA, S_BRESP, S_RRESP} !== '0) begin
      errors++; $display("FAIL reset_data got %h/%b/%b exp 0", S_RDATA, S_BRESP, S_RRESP);
    end
    apply_reset();
    @(negedge ACLK);
    checks++;
    if ({S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID} !== 5'b0) begin
      errors++; $display("FAIL post_reset_idle got %b exp 00000", {S_AWREADY, S_WREADY, S_ARREADY, S_BVALID, S_RVALID});
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_basic();
    logic [1:0] resp; logic [DW-1:0] d; int lat; bit ok, eb, un;
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp, ok, eb, un);
    model_write(32'h08, 32'hDEADBEEF, 4'hF);
    checks++;
    if (!ok || resp !== 2'b00 || eb) begin
      errors++; $display("FAIL basic_write got ok=%0d resp=%b early=%0d exp ok=1 resp=00 early=0", ok, resp, eb);
    end
    do_read(32'h08, 0, d, resp, lat, ok, un);
    checks++;
    if (!ok || d !== 32'hDEADBEEF || resp !== 2'b00) begin
      errors++; $display("FAIL basic_read got ok=%0d %h/%b exp deadbeef/00", ok, d, resp);
    end
    checks++;
    if (lat !== 1) begin
      errors++; $display("FAIL basic_rd_latency got %0d exp 1", lat);
    end
    @(negedge ACLK);
    checks++;
    if (S_RVALID !== 1'b0 || S_RDATA !== '0) begin
      errors++; $display("FAIL rdata_idle_zero got %b/%h exp 0/0", S_RVALID, S_RDATA);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_w_before_aw();
    logic [1:0] resp; logic [DW-1:0] d; int lat; bit ok, eb, un;
    do_write(32'h0C, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp, ok, eb, un);
    model_write(32'h0C, 32'hFFFFFFFF, 4'hF);
    do_write(32'h0C, 32'h11223344, 4'h5, 3, 0, 0, resp, ok, eb, un);
    model_write(32'h0C, 32'h11223344, 4'h5);
    checks++;
    if (!ok || resp !== 2'b00 || eb) begin
      errors++; $display("FAIL w_first_write got ok=%0d resp=%b early=%0d exp 1/00/0", ok, resp, eb);
    end
    do_read(32'h0C, 0, d, resp, lat, ok, un);
    checks++;
    if (!ok || d !== 32'hFF22FF44) begin
      errors++; $display("FAIL w_first_strobe got %h exp ff22ff44", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp; logic [DW-1:0] d; int lat; bit ok, eb, un;
    do_write(32'h80, 32'hA5A5A5A5, 4'hF, 1, 0, 0, resp, ok, eb, un);
    checks++;
    if (!ok || resp !== 2'b10) begin
      errors++; $display("FAIL oor_bresp got ok=%0d %b exp 10", ok, resp);
    end
    do_write(32'h1000_0008, 32'h5A5A5A5A, 4'hF, 0, 2, 0, resp, ok, eb, un);
    checks++;
    if (!ok || resp !== 2'b10) begin
      errors++; $display("FAIL oor_high_bresp got ok=%0d %b exp 10", ok, resp);
    end
    do_read(32'h00, 0, d, resp, lat, ok, un);
    checks++;
    if (d !== model_read(32'h00)) begin
      errors++; $display("FAIL oor_no_alias0 got %h exp %h", d, model_read(32'h00));
    end
    do_read(32'h08, 0, d, resp, lat, ok, un);
    checks++;
    if (d !== model_read(32'h08)) begin
      errors++; $display("FAIL oor_no_alias8 got %h exp %h", d, model_read(32'h08));
    end
    do_read(32'h80, 0, d, resp, lat, ok, un);
    checks++;
    if (!ok || d !== '0 || resp !== 2'b10) begin
      errors++; $display("FAIL oor_read got %h/%b exp 0/10", d, resp);
    end
  endtask

  task automatic test_strb_zero();
    logic [1:0] resp; logic [DW-1:0] d; int lat; bit ok, eb, un;
    do_write(32'h08, 32'h01234567, 4'h0, 0, 1, 0, resp, ok, eb, un);
    checks++;
    if (!ok || resp !== 2'b00) begin
      errors++; $display("FAIL strb0_bresp got %b exp 00", resp);
    end
    do_read(32'h08, 0, d, resp, lat, ok, un);
    checks++;
    if (d !== model_read(32'h08)) begin
      errors++; $display("FAIL strb0_unchanged got %h exp %h", d, model_read(32'h08));
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] resp; logic [DW-1:0] d; int lat; bit ok, eb, un;
    do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 5, resp, ok, eb, un);
    model_write(32'h40, 32'hCAFEF00D, 4'hF);
    checks++;
    if (!ok || un || resp !== 2'b00) begin
      errors++; $display("FAIL bready_hold got ok=%0d unstable=%0d resp=%b exp 1/0/00", ok, un, resp);
    end
    do_read(32'h40, 5, d, resp, lat, ok, un);
    checks++;
    if (!ok || un || d !== 32'hCAFEF00D) begin
      errors++; $display("FAIL rready_hold got ok=%0d unstable=%0d %h exp 1/0/cafef00d", ok, un, d);
    end
  endtask

  task automatic test_arbitration();
    logic [AW-1:0] a1 = 32'h10, a2 = 32'h14;
    logic [DW-1:0] d1, d2, d, exp_rd;
    logic [1:0] resp;
    bit rd_early = 0, wr_early = 0, ok = 1, rok, un;
    int cyc, lat;
    d1 = $urandom; d2 = $urandom;
    apply_reset();
    S_AWADDR = a1; S_WDATA = d1; S_WSTRB = 4'hF; S_ARADDR = a1;
    S_AWVALID = 1; S_WVALID = 1; S_ARVALID = 1; S_BREADY = 1; S_RREADY = 1;
    cyc = 0;
    forever begin
      @(negedge ACLK);
      if (S_ARREADY) rd_early = 1;
      if (S_AWREADY && S_WREADY) break;
      if (++cyc > 20) begin ok = 0; break; end
    end
    @(posedge ACLK); #1;
    S_AWVALID = 0; S_WVALID = 0;
    cyc = 0;
    forever begin
      @(negedge ACLK);
      if (S_ARREADY) rd_early = 1;
      if (S_BVALID) break;
      if (++cyc > 20) begin ok = 0; break; end
    end
    @(posedge ACLK); #1;
    model_write(a1, d1, 4'hF);
    checks++;
    if (!ok || rd_early) begin
      errors++; $display("FAIL arb_first_write got ok=%0d read_first=%0d exp 1/0", ok, rd_early);
    end
    exp_rd = model_read(a1);
    S_AWADDR = a2; S_WDATA = d2; S_AWVALID = 1; S_WVALID = 1;
    @(negedge ACLK);
    checks++;
    if (S_ARREADY !== 1'b1) begin
      errors++; $display("FAIL arb_read_second got arready=%b exp 1", S_ARREADY);
    end
    @(posedge ACLK); #1;
    S_ARVALID = 0;
    cyc = 0; ok = 1;
    forever begin
      @(negedge ACLK);
      if (S_AWREADY || S_WREADY) wr_early = 1;
      if (S_RVALID) break;
      if (++cyc > 20) begin ok = 0; break; end
    end
    d = S_RDATA;
    @(posedge ACLK); #1;
    checks++;
    if (!ok || d !== exp_rd || wr_early) begin
      errors++; $display("FAIL arb_read_data got ok=%0d %h wr_early=%0d exp 1/%h/0", ok, d, wr_early, exp_rd);
    end
    cyc = 0; ok = 1;
    forever begin
      @(negedge ACLK);
      if (S_AWREADY && S_WREADY) break;
      if (++cyc > 20) begin ok = 0; break; end
    end
    @(posedge ACLK); #1;
    S_AWVALID = 0; S_WVALID = 0;
    cyc = 0;
    forever begin
      @(negedge ACLK);
      if (S_BVALID) break;
      if (++cyc > 20) begin ok = 0; break; end
    end
    @(posedge ACLK); #1;
    model_write(a2, d2, 4'hF);
    S_BREADY = 0; S_RREADY = 0;
    do_read(a2, 0, d, resp, lat, rok, un);
    checks++;
    if (!ok || !rok || d !== d2) begin
      errors++; $display("FAIL arb_second_write got ok=%0d/%0d %h exp %h", ok, rok, d, d2);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a; logic [DW-1:0] d; logic [3:0] s; logic [1:0] resp;
    int lat; bit ok, eb, un;
    for (int n = 0; n < 60; n++) begin
      a = AW'($urandom_range(0, NR + 3) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom; s = 4'($urandom);
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), resp, ok, eb, un);
        checks++;
        if (!ok || eb || un || resp !== (in_range(a) ? 2'b00 : 2'b10)) begin
          errors++; $display("FAIL rand_write a=%h got ok=%0d early=%0d unst=%0d resp=%b exp resp=%b",
                             a, ok, eb, un, resp, in_range(a) ? 2'b00 : 2'b10);
        end
        model_write(a, d, s);
      end else begin
        do_read(a, $urandom_range(0, 2), d, resp, lat, ok, un);
        checks++;
        if (!ok || un || lat !== 1 || d !== model_read(a) || resp !== (in_range(a) ? 2'b00 : 2'b10)) begin
          errors++; $display("FAIL rand_read a=%h got %h/%b lat=%0d exp %h/%b lat=1",
                             a, d, resp, lat, model_read(a), in_range(a) ? 2'b00 : 2'b10);
        end
      end
    end
  endtask

  task automatic test_reset_in_wresp();
    logic [DW-1:0] d; logic [1:0] resp; int lat, cyc = 0; bit ok = 1, stale = 0, rok, un, bad = 0;
    S_AWADDR = 32'h20; S_WDATA = 32'h87654321; S_WSTRB = 4'hF; S_AWVALID = 1; S_WVALID = 1; S_BREADY = 0;
    forever begin
      @(negedge ACLK);
      if (S_AWREADY && S_WREADY) break;
      if (++cyc > 20) begin ok = 0; break; end
    end
    @(posedge ACLK); #1;
    S_AWVALID = 0; S_WVALID = 0;
    @(negedge ACLK);
    checks++;
    if (!ok || S_BVALID !== 1'b1) begin
      errors++; $display("FAIL rst_setup got bvalid=%b exp 1", S_BVALID);
    end
    #2 ARESETN = 0;
    #1;
    checks++;
    if (S_BVALID !== 1'b0 || S_RVALID !== 1'b0 || S_BRESP !== 2'b00) begin
      errors++; $display("FAIL rst_async_drop got %b/%b/%b exp 0/0/00", S_BVALID, S_RVALID, S_BRESP);
    end
    @(posedge ACLK); #1;
    ARESETN = 1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      if (S_BVALID) stale = 1;
    end
    checks++;
    if (stale) begin
      errors++; $display("FAIL rst_stale_bvalid got 1 exp 0");
    end
    @(posedge ACLK); #1;
    for (int i = 0; i < NR; i++) begin
      do_read(AW'(i * 4), 0, d, resp, lat, rok, un);
      if (!rok || d !== model[i]) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL rst_regs_cleared got nonzero exp all 0");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_w_before_aw();
    test_out_of_range();
    test_strb_zero();
    test_backpressure();
    test_arbitration();
    test_random();
    test_reset_in_wresp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
